// File: rtl/nway_cache.sv
// N-way set-associative write-back/write-allocate cache with tree PLRU replacement.
// Optional hit/miss counters are built when CACHE_PERF_CNT_EN is defined.
module nway_cache #(
  parameter int SETS = 4,
  parameter int WAYS = 2
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]  perf_hit,
  output logic [31:0]  perf_miss
`endif
);

  localparam int S  = $clog2(SETS);
  localparam int TW = 28 - S;
  localparam int LV = $clog2(WAYS);
  localparam int WI = (LV > 0) ? LV : 1;
  localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;

  typedef enum logic [1:0] {COMP, WB, ALLC} state_t;

  state_t        state;
  state_t        state_nx;

  logic          rst_r;
  logic          mem_ready_r;
  logic [127:0]  mem_rdata_r;

  logic          line_valid [SETS][WAYS];
  logic          line_dirty [SETS][WAYS];
  logic [TW-1:0] line_tag   [SETS][WAYS];
  logic [127:0]  line_data  [SETS][WAYS];
  logic [PW-1:0] plru       [SETS];

  logic [S-1:0]  idx;
  logic [TW-1:0] tag_in;
  logic [1:0]    word;
  logic          req;
  logic          hit;
  logic [WI-1:0] hit_way;
  logic [WI-1:0] vict;
  logic          vict_found;
  logic          vict_dirty;
  logic          fill;
  logic [127:0]  hit_line;
  logic [127:0]  fill_line;

  assign word   = proc_addr[1:0];
  assign idx    = proc_addr[S+1:2];
  assign tag_in = proc_addr[29:S+2];
  assign req    = proc_read | proc_write;

  // Heap-ordered tree: node n (1-based) lives in bit n-1; a 1 steers toward the upper half.
  function automatic logic [WI-1:0] plru_victim(input logic [PW-1:0] bits);
    int unsigned   node;
    logic [PW-1:0] sh;
    node = 1;
    for (int unsigned l = 0; l < LV; l++) begin
      sh   = bits >> (node - 1);
      node = 2 * node + (sh[0] ? 1 : 0);
    end
    return WI'(node - WAYS);
  endfunction

  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] bits,
                                               input logic [WI-1:0] way);
    logic [PW-1:0] r;
    logic [PW-1:0] mask;
    logic [WI-1:0] ws;
    int unsigned   node;
    r    = bits;
    node = 1;
    for (int unsigned l = 0; l < LV; l++) begin
      ws   = way >> (LV - 1 - l);
      mask = PW'(1) << (node - 1);
      r    = ws[0] ? (r & ~mask) : (r | mask);
      node = 2 * node + (ws[0] ? 1 : 0);
    end
    return r;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (line_valid[idx][w] && (line_tag[idx][w] == tag_in)) begin
        hit     = 1'b1;
        hit_way = WI'(w);
      end
    end
  end

  always_comb begin
    vict       = plru_victim(plru[idx]);
    vict_found = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!vict_found && !line_valid[idx][w]) begin
        vict       = WI'(w);
        vict_found = 1'b1;
      end
    end
  end

  assign vict_dirty = line_valid[idx][vict] & line_dirty[idx][vict];
  assign fill       = (state == ALLC) & mem_ready_r;
  assign hit_line   = line_data[idx][hit_way];

  always_comb begin
    fill_line = mem_rdata_r;
    if (proc_write) fill_line[{word, 5'b0} +: 32] = proc_wdata;
  end

  always_ff @(posedge clk) begin
    rst_r       <= proc_reset;
    mem_ready_r <= mem_ready;
    mem_rdata_r <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst_r) state <= COMP;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      COMP:    if (req && !hit) state_nx = vict_dirty ? WB : ALLC;
      WB:      if (mem_ready_r) state_nx = ALLC;
      ALLC:    if (mem_ready_r) state_nx = COMP;
      default: state_nx = COMP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_r) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        plru[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          line_valid[s][w] <= 1'b0;
          line_dirty[s][w] <= 1'b0;
        end
      end
    end else if (state == COMP && req && hit) begin
      plru[idx] <= plru_touch(plru[idx], hit_way);
      if (proc_write) line_dirty[idx][hit_way] <= 1'b1;
    end else if (fill) begin
      plru[idx]             <= plru_touch(plru[idx], vict);
      line_valid[idx][vict] <= 1'b1;
      line_dirty[idx][vict] <= proc_write;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_r) begin
      if (state == COMP && req && hit && proc_write) begin
        line_data[idx][hit_way][{word, 5'b0} +: 32] <= proc_wdata;
      end else if (fill) begin
        line_data[idx][vict] <= fill_line;
        line_tag[idx][vict]  <= tag_in;
      end
    end
  end

  // Requests drop as soon as the completion or a registered reset is seen.
  assign mem_write  = (state == WB)   & ~mem_ready_r & ~rst_r;
  assign mem_read   = (state == ALLC) & ~mem_ready_r & ~rst_r;
  assign mem_addr   = (state == WB) ? {line_tag[idx][vict], idx} : proc_addr[29:2];
  assign mem_wdata  = line_data[idx][vict];
  assign proc_stall = req & ~hit;
  assign proc_rdata = hit ? hit_line[{word, 5'b0} +: 32] : 32'h0;

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst_r) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else begin
      if (state == COMP && req && hit && perf_hit != '1)
        perf_hit <= perf_hit + 32'd1;
      if (state == COMP && state_nx != COMP && perf_miss != '1)
        perf_miss <= perf_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nway_cache.sv
// Directed bench for nway_cache: instance 0 uses defaults (4 sets, 2 ways), instance 1 uses 4 ways.
module tb_nway_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd     [2];
  logic         wr     [2];
  logic [29:0]  addr   [2];
  logic [31:0]  wdata  [2];
  logic [31:0]  rdata  [2];
  logic         stall  [2];
  logic         mrd    [2];
  logic         mwr    [2];
  logic [27:0]  maddr  [2];
  logic [127:0] mwdata [2];
  logic [127:0] mrdata [2];
  logic         mready [2];
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]  phit   [2];
  logic [31:0]  pmiss  [2];
`endif

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  nway_cache #(.SETS(4), .WAYS(2)) u_c2 (
    .clk(clk), .proc_reset(rst), .proc_read(rd[0]), .proc_write(wr[0]),
    .proc_addr(addr[0]), .proc_wdata(wdata[0]), .proc_rdata(rdata[0]),
    .proc_stall(stall[0]), .mem_read(mrd[0]), .mem_write(mwr[0]),
    .mem_addr(maddr[0]), .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0]),
    .mem_ready(mready[0])
`ifdef CACHE_PERF_CNT_EN
    , .perf_hit(phit[0]), .perf_miss(pmiss[0])
`endif
  );

  nway_cache #(.SETS(4), .WAYS(4)) u_c4 (
    .clk(clk), .proc_reset(rst), .proc_read(rd[1]), .proc_write(wr[1]),
    .proc_addr(addr[1]), .proc_wdata(wdata[1]), .proc_rdata(rdata[1]),
    .proc_stall(stall[1]), .mem_read(mrd[1]), .mem_write(mwr[1]),
    .mem_addr(maddr[1]), .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1]),
    .mem_ready(mready[1])
`ifdef CACHE_PERF_CNT_EN
    , .perf_hit(phit[1]), .perf_miss(pmiss[1])
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int d, input logic r, input logic w,
                         input logic [29:0] a, input logic [31:0] wd);
    rd[d]    = r;
    wr[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
  endtask

  // mode 0: probe and withdraw before the edge; 1: hold across one edge; 2: leave asserted
  task automatic look(input int d, input string tag, input logic [29:0] a, input logic w,
                      input logic [31:0] wd, input logic exp_stall, input logic [31:0] exp_rd,
                      input int mode);
    set_req(d, !w, w, a, wd);
    #1;
    check({tag, "_stall"}, stall[d], exp_stall);
    if (!w && !exp_stall) check({tag, "_rdata"}, rdata[d], exp_rd);
    if (mode == 1) begin
      @(negedge clk);
      set_req(d, 1'b0, 1'b0, '0, '0);
    end else if (mode == 0) begin
      #1;
      set_req(d, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
    end
  endtask

  task automatic wait_req(input int d, input string tag, output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mrd[d] || mwr[d]) && n < 40);
    check({tag, "_seen"}, (n < 40), 1'b1);
  endtask

  task automatic serve(input int d, input string tag, input logic exp_wr,
                       input logic [27:0] exp_addr, input logic [127:0] fill_data,
                       output logic [127:0] wd_seen, output int unsigned n);
    wait_req(d, tag, n);
    check({tag, "_kind"}, mwr[d], exp_wr);
    check({tag, "_addr"}, maddr[d], exp_addr);
    wd_seen   = mwdata[d];
    mrdata[d] = fill_data;
    mready[d] = 1'b1;
    @(negedge clk);
    mready[d] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] wd;
    int unsigned  n;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      set_req(d, 1'b0, 1'b0, '0, '0);
      mrdata[d] = '0;
      mready[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_mem_read", mrd[d], 1'b0);
      check("rst_mem_write", mwr[d], 1'b0);
      check("rst_stall", stall[d], 1'b0);
      check("rst_rdata", rdata[d], 32'h0);
    end

    // cold read miss in set 1
    look(0, "cold", 30'h4, 1'b0, '0, 1'b1, '0, 2);
    serve(0, "cold_allc", 1'b0, 28'h1, 128'hDDDD_CCCC_BBBB_AAAA, wd, n);
    check("cold_latency", n, 1);
    look(0, "cold_hit", 30'h4, 1'b0, '0, 1'b0, 32'hBBBB_AAAA, 1);
    look(0, "cold_w1", 30'h5, 1'b0, '0, 1'b0, 32'hDDDD_CCCC, 1);
    look(0, "cold_w2", 30'h6, 1'b0, '0, 1'b0, 32'h0, 1);

    // write miss merges data at fill time
    look(0, "wmiss", 30'h0, 1'b1, 32'h1234_5678, 1'b1, '0, 2);
    serve(0, "wmiss_allc", 1'b0, 28'h0, 128'h4444_4444_3333_3333_2222_2222_1111_1111, wd, n);
    look(0, "wmiss_hit", 30'h0, 1'b1, 32'h1234_5678, 1'b0, '0, 1);
    look(0, "wmiss_rd0", 30'h0, 1'b0, '0, 1'b0, 32'h1234_5678, 1);
    look(0, "wmiss_rd1", 30'h1, 1'b0, '0, 1'b0, 32'h2222_2222, 1);

    // second tag in set 0 goes to the invalid way, no write-back
    look(0, "inv", 30'h10, 1'b0, '0, 1'b1, '0, 2);
    serve(0, "inv_fill", 1'b0, 28'h4, 128'h5555_5555, wd, n);
    look(0, "inv_hit1", 30'h10, 1'b0, '0, 1'b0, 32'h5555_5555, 1);
    look(0, "inv_hit0", 30'h0, 1'b0, '0, 1'b0, 32'h1234_5678, 1);
    look(0, "inv_hit1b", 30'h10, 1'b0, '0, 1'b0, 32'h5555_5555, 1);

    // dirty eviction of tag 0
    look(0, "evict", 30'h20, 1'b0, '0, 1'b1, '0, 2);
    serve(0, "evict_wb", 1'b1, 28'h0, '0, wd, n);
    check("evict_wdata", wd[31:0], 32'h1234_5678);
    serve(0, "evict_allc", 1'b0, 28'h8, 128'h6666_6666, wd, n);
    look(0, "evict_hit", 30'h20, 1'b0, '0, 1'b0, 32'h6666_6666, 1);
    look(0, "evict_t1", 30'h10, 1'b0, '0, 1'b0, 32'h5555_5555, 1);
    look(0, "evict_t0", 30'h0, 1'b0, '0, 1'b1, '0, 0);

    // make both ways dirty, then reset while the write-back is pending
    look(0, "dirty2", 30'h20, 1'b1, 32'hCAFE_0001, 1'b0, '0, 1);
    look(0, "dirty1", 30'h10, 1'b1, 32'hCAFE_0002, 1'b0, '0, 1);
    look(0, "rstwb", 30'h30, 1'b0, '0, 1'b1, '0, 2);
    wait_req(0, "rstwb", n);
    check("rstwb_wr", mwr[0], 1'b1);
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    check("rstwb_drop", mwr[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rstwb_after_wr", mwr[0], 1'b0);
    check("rstwb_after_rd", mrd[0], 1'b0);

    // after reset every line is invalid: clean fills only
    look(0, "post", 30'h30, 1'b0, '0, 1'b1, '0, 2);
    serve(0, "post_allc", 1'b0, 28'hC, 128'h7777_7777, wd, n);
    look(0, "post_hit", 30'h30, 1'b0, '0, 1'b0, 32'h7777_7777, 1);
    look(0, "post_inv", 30'h4, 1'b0, '0, 1'b1, '0, 2);
    serve(0, "post4_allc", 1'b0, 28'h1, 128'hDDDD_CCCC_BBBB_AAAA, wd, n);
    look(0, "post4_hit", 30'h4, 1'b0, '0, 1'b0, 32'hBBBB_AAAA, 1);
    look(0, "post_hit2", 30'h30, 1'b0, '0, 1'b0, 32'h7777_7777, 1);
`ifdef CACHE_PERF_CNT_EN
    check("perf_hit", phit[0], 32'd3);
    check("perf_miss", pmiss[0], 32'd2);
    check("perf_idle_hit", phit[1], 32'd0);
`endif

    // 4-way PLRU: fill tags 0..3, hit 0 and 2, then tag 4 must replace tag 1
    for (int t = 0; t < 4; t++) begin
      look(1, "p_fill", 30'(t * 16), 1'b0, '0, 1'b1, '0, 2);
      serve(1, "p_fill", 1'b0, 28'(t * 4), 128'(160 + t), wd, n);
      look(1, "p_fill_hit", 30'(t * 16), 1'b0, '0, 1'b0, 32'(160 + t), 1);
    end
    look(1, "p_hit0", 30'h00, 1'b0, '0, 1'b0, 32'hA0, 1);
    look(1, "p_hit2", 30'h20, 1'b0, '0, 1'b0, 32'hA2, 1);
    look(1, "p_miss4", 30'h40, 1'b0, '0, 1'b1, '0, 2);
    serve(1, "p_evict", 1'b0, 28'h10, 128'hA4, wd, n);
    look(1, "p_hit4", 30'h40, 1'b0, '0, 1'b0, 32'hA4, 1);
    look(1, "p_keep0", 30'h00, 1'b0, '0, 1'b0, 32'hA0, 0);
    look(1, "p_keep2", 30'h20, 1'b0, '0, 1'b0, 32'hA2, 0);
    look(1, "p_keep3", 30'h30, 1'b0, '0, 1'b0, 32'hA3, 0);
    look(1, "p_gone1", 30'h10, 1'b0, '0, 1'b1, '0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
